// File: rtl/trap_controller.sv
// Trap sequencer for the single-cycle RV32I core: takes exceptions, interrupts and MRET,
// owns mstatus.MIE/MPIE, mepc and mcause, and redirects fetch to mtvec or mepc.
module trap_controller #(
    parameter int unsigned XLEN      = 32,
    parameter bit          RESET_MIE = 1'b0
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    input  logic [XLEN-1:0] I_pc,
    input  logic            I_ecall,
    input  logic            I_ebreak,
    input  logic            I_illegal,
    input  logic            I_mret,
    input  logic            I_irq_ext,
    input  logic            I_irq_timer,
    input  logic [XLEN-1:0] I_mtvec,
    input  logic            I_csr_wen,
    input  logic [11:0]     I_csr_addr,
    input  logic [XLEN-1:0] I_csr_wdata,
    output logic            O_stall,
    output logic            O_kill,
    output logic            O_pc_override,
    output logic [XLEN-1:0] O_pc_target,
    output logic            O_busy,
    output logic [XLEN-1:0] O_mstatus,
    output logic [XLEN-1:0] O_mepc,
    output logic [XLEN-1:0] O_mcause
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = XLEN'(2);
    localparam logic [XLEN-1:0] CAUSE_EBREAK    = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_ECALL     = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_IRQ_EXT   = {1'b1, (XLEN-1)'(11)};
    localparam logic [XLEN-1:0] CAUSE_IRQ_TIMER = {1'b1, (XLEN-1)'(7)};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_JUMP,
        ST_RET
    } state_e;

    state_e          state_q;
    logic            stall_q;
    logic            override_q;
    logic            busy_q;
    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] pc_q;

    logic            is_idle;
    logic            trap_req;
    logic            mret_req;
    logic            kill_c;
    logic [XLEN-1:0] cause_d;
    logic            unused_bits;

    assign is_idle = (state_q == ST_IDLE);

    always_comb begin
        trap_req = 1'b0;
        cause_d  = '0;
        if (I_illegal) begin
            trap_req = 1'b1;
            cause_d  = CAUSE_ILLEGAL;
        end else if (I_ebreak) begin
            trap_req = 1'b1;
            cause_d  = CAUSE_EBREAK;
        end else if (I_ecall) begin
            trap_req = 1'b1;
            cause_d  = CAUSE_ECALL;
        end else if (I_irq_ext && mie_q) begin
            trap_req = 1'b1;
            cause_d  = CAUSE_IRQ_EXT;
        end else if (I_irq_timer && mie_q) begin
            trap_req = 1'b1;
            cause_d  = CAUSE_IRQ_TIMER;
        end
        trap_req = trap_req & I_valid & is_idle;
    end

    assign mret_req = I_valid & I_mret & is_idle & ~trap_req;

    // Kill is the only path from the event to the outputs; gate it so reset forces it low.
    assign kill_c        = (trap_req | mret_req) & ~I_rst;
    assign O_kill        = kill_c;
    assign O_stall       = kill_c | stall_q;
    assign O_pc_override = override_q;
    assign O_busy        = busy_q;
    assign O_mstatus     = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
    assign O_mepc        = mepc_q;
    assign O_mcause      = mcause_q;

    always_comb begin
        O_pc_target = '0;
        case (state_q)
            ST_JUMP: O_pc_target = {I_mtvec[XLEN-1:2], 2'b00};
            ST_RET:  O_pc_target = mepc_q;
            default: O_pc_target = '0;
        endcase
    end

    assign unused_bits = ^{I_mtvec[1:0], pc_q[1:0]};

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            stall_q    <= 1'b0;
            override_q <= 1'b0;
            busy_q     <= 1'b0;
            mie_q      <= RESET_MIE;
            mpie_q     <= 1'b0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            cause_q    <= '0;
            pc_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap_req) begin
                        cause_q <= cause_d;
                        pc_q    <= I_pc;
                        state_q <= ST_SAVE;
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (mret_req) begin
                        state_q    <= ST_RET;
                        override_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (I_csr_wen) begin
                        case (I_csr_addr)
                            CSR_MSTATUS: begin
                                mie_q  <= I_csr_wdata[3];
                                mpie_q <= I_csr_wdata[7];
                            end
                            CSR_MEPC:   mepc_q   <= {I_csr_wdata[XLEN-1:2], 2'b00};
                            CSR_MCAUSE: mcause_q <= I_csr_wdata;
                            default: ;
                        endcase
                    end
                end
                ST_SAVE: begin
                    mepc_q     <= {pc_q[XLEN-1:2], 2'b00};
                    mcause_q   <= cause_q;
                    mpie_q     <= mie_q;
                    mie_q      <= 1'b0;
                    state_q    <= ST_JUMP;
                    stall_q    <= 1'b0;
                    override_q <= 1'b1;
                end
                ST_JUMP: begin
                    state_q    <= ST_IDLE;
                    override_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                ST_RET: begin
                    mie_q      <= mpie_q;
                    mpie_q     <= 1'b1;
                    state_q    <= ST_IDLE;
                    override_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    stall_q    <= 1'b0;
                    override_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed vector table, reset/masking sequences and a
// randomized run against a schedule-based reference model.
module tb_trap_controller;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        ecall, ebreak, illegal, mret, irq_ext, irq_tmr;
    logic [31:0] mtvec;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        stall, kill, ovr, busy;
    logic [31:0] target, mstatus, mepc, mcause;

    int checks = 0;
    int errors = 0;

    trap_controller #(.XLEN(32), .RESET_MIE(1'b0)) dut (
        .I_clk(clk), .I_rst(rst), .I_valid(valid), .I_pc(pc),
        .I_ecall(ecall), .I_ebreak(ebreak), .I_illegal(illegal), .I_mret(mret),
        .I_irq_ext(irq_ext), .I_irq_timer(irq_tmr), .I_mtvec(mtvec),
        .I_csr_wen(csr_wen), .I_csr_addr(csr_addr), .I_csr_wdata(csr_wdata),
        .O_stall(stall), .O_kill(kill), .O_pc_override(ovr), .O_pc_target(target),
        .O_busy(busy), .O_mstatus(mstatus), .O_mepc(mepc), .O_mcause(mcause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ev = {illegal, ebreak, ecall, mret, irq_ext, irq_timer}; ctl = {kill, stall, override, busy}
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  ev;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ctl;
        logic [31:0] tgt;
        logic [31:0] ms;
        logic [31:0] mepc;
        logic [31:0] mcause;
    } vec_t;

    typedef struct {
        bit stall;
        bit ovr;
        int tgt_src;   // 1: mtvec, 2: mepc
        int upd;       // 1: save trap context, 2: restore from MRET
    } step_t;

    vec_t  tbl[30];
    step_t sched[$];

    bit          m_mie, m_mpie;
    logic [31:0] m_mepc, m_mcause, m_lat_pc, m_lat_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        valid = 0; pc = '0; ecall = 0; ebreak = 0; illegal = 0; mret = 0;
        irq_ext = 0; irq_tmr = 0; csr_wen = 0; csr_addr = '0; csr_wdata = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        valid = v.valid; pc = v.pc;
        {illegal, ebreak, ecall, mret, irq_ext, irq_tmr} = v.ev;
        csr_wen = v.wen; csr_addr = v.addr; csr_wdata = v.wdata;
        mtvec = 32'h201;
    endtask

    task automatic fill_table();
        tbl[0]  = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0000, 32'h0,   32'h00, 32'h0,   32'h0};
        tbl[1]  = '{1'b0, 32'h0,   6'b000000, 1'b1, 12'h341, 32'h103,      4'b0000, 32'h0,   32'h00, 32'h0,   32'h0};
        tbl[2]  = '{1'b0, 32'h0,   6'b000000, 1'b1, 12'h342, 32'h5,        4'b0000, 32'h0,   32'h00, 32'h100, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,   6'b000000, 1'b1, 12'h305, 32'hFFFFFFFF, 4'b0000, 32'h0,   32'h00, 32'h100, 32'h5};
        tbl[4]  = '{1'b1, 32'h100, 6'b001000, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h00, 32'h100, 32'h5};
        tbl[5]  = '{1'b1, 32'h0,   6'b100000, 1'b1, 12'h342, 32'h77,       4'b0101, 32'h0,   32'h00, 32'h100, 32'h5};
        tbl[6]  = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h200, 32'h00, 32'h100, 32'hB};
        tbl[7]  = '{1'b0, 32'h0,   6'b000000, 1'b1, 12'h300, 32'h88,       4'b0000, 32'h0,   32'h00, 32'h100, 32'hB};
        tbl[8]  = '{1'b1, 32'h244, 6'b100010, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h88, 32'h100, 32'hB};
        tbl[9]  = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0101, 32'h0,   32'h88, 32'h100, 32'hB};
        tbl[10] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h200, 32'h80, 32'h244, 32'h2};
        tbl[11] = '{1'b1, 32'h300, 6'b000010, 1'b1, 12'h300, 32'h08,       4'b0000, 32'h0,   32'h80, 32'h244, 32'h2};
        tbl[12] = '{1'b1, 32'h304, 6'b000010, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h08, 32'h244, 32'h2};
        tbl[13] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0101, 32'h0,   32'h08, 32'h244, 32'h2};
        tbl[14] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h200, 32'h80, 32'h304, 32'h8000000B};
        tbl[15] = '{1'b0, 32'h0,   6'b000000, 1'b1, 12'h300, 32'h08,       4'b0000, 32'h0,   32'h80, 32'h304, 32'h8000000B};
        tbl[16] = '{1'b1, 32'h40,  6'b000001, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h08, 32'h304, 32'h8000000B};
        tbl[17] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0101, 32'h0,   32'h08, 32'h304, 32'h8000000B};
        tbl[18] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h200, 32'h80, 32'h40,  32'h80000007};
        tbl[19] = '{1'b1, 32'h44,  6'b000100, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h80, 32'h40,  32'h80000007};
        tbl[20] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h40,  32'h80, 32'h40,  32'h80000007};
        tbl[21] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0000, 32'h0,   32'h88, 32'h40,  32'h80000007};
        tbl[22] = '{1'b1, 32'h48,  6'b000100, 1'b1, 12'h342, 32'h99,       4'b1100, 32'h0,   32'h88, 32'h40,  32'h80000007};
        tbl[23] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h40,  32'h88, 32'h40,  32'h80000007};
        tbl[24] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0000, 32'h0,   32'h88, 32'h40,  32'h80000007};
        tbl[25] = '{1'b1, 32'h80,  6'b011100, 1'b0, 12'h000, 32'h0,        4'b1100, 32'h0,   32'h88, 32'h40,  32'h80000007};
        tbl[26] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0101, 32'h0,   32'h88, 32'h40,  32'h80000007};
        tbl[27] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0011, 32'h200, 32'h80, 32'h80,  32'h3};
        tbl[28] = '{1'b0, 32'h0,   6'b001000, 1'b0, 12'h000, 32'h0,        4'b0000, 32'h0,   32'h80, 32'h80,  32'h3};
        tbl[29] = '{1'b0, 32'h0,   6'b000000, 1'b0, 12'h000, 32'h0,        4'b0000, 32'h0,   32'h80, 32'h80,  32'h3};
    endtask

    task automatic random_cycle(input int n);
        logic [11:0] csr_list [5];
        bit          e_trap, e_mret, e_kill, e_stall, e_ovr, e_busy;
        logic [31:0] e_cause, e_tgt;
        step_t       s;
        csr_list = '{12'h300, 12'h341, 12'h342, 12'h305, 12'h7C0};

        valid     = ($urandom_range(9) != 0);
        pc        = $urandom;
        illegal   = ($urandom_range(15) == 0);
        ebreak    = ($urandom_range(15) == 0);
        ecall     = ($urandom_range(15) == 0);
        mret      = ($urandom_range(9) == 0);
        irq_ext   = ($urandom_range(7) == 0);
        irq_tmr   = ($urandom_range(7) == 0);
        csr_wen   = ($urandom_range(3) == 0);
        csr_addr  = csr_list[$urandom_range(4)];
        csr_wdata = $urandom;
        mtvec     = $urandom;

        e_trap = 0; e_mret = 0; e_cause = '0;
        e_kill = 0; e_stall = 0; e_ovr = 0; e_busy = 0; e_tgt = '0;
        if (sched.size() > 0) begin
            s       = sched[0];
            e_stall = s.stall;
            e_ovr   = s.ovr;
            e_busy  = 1;
            e_tgt   = (s.tgt_src == 1) ? (mtvec & 32'hFFFFFFFC) : m_mepc;
        end else begin
            if (valid) begin
                if (illegal)                  begin e_trap = 1; e_cause = 32'd2;        end
                else if (ebreak)              begin e_trap = 1; e_cause = 32'd3;        end
                else if (ecall)               begin e_trap = 1; e_cause = 32'd11;       end
                else if (m_mie && irq_ext)    begin e_trap = 1; e_cause = 32'h8000000B; end
                else if (m_mie && irq_tmr)    begin e_trap = 1; e_cause = 32'h80000007; end
                e_mret = mret && !e_trap;
            end
            e_kill  = e_trap || e_mret;
            e_stall = e_kill;
        end

        @(negedge clk);
        chk($sformatf("rnd%0d_kill", n),     {31'b0, kill},  {31'b0, e_kill});
        chk($sformatf("rnd%0d_stall", n),    {31'b0, stall}, {31'b0, e_stall});
        chk($sformatf("rnd%0d_override", n), {31'b0, ovr},   {31'b0, e_ovr});
        chk($sformatf("rnd%0d_busy", n),     {31'b0, busy},  {31'b0, e_busy});
        if (e_ovr) chk($sformatf("rnd%0d_target", n), target, e_tgt);
        chk($sformatf("rnd%0d_mstatus", n), mstatus, {24'b0, m_mpie, 3'b0, m_mie, 3'b0});
        chk($sformatf("rnd%0d_mepc", n),    mepc,    m_mepc);
        chk($sformatf("rnd%0d_mcause", n),  mcause,  m_mcause);

        if (sched.size() > 0) begin
            if (s.upd == 1) begin
                m_mepc   = m_lat_pc & 32'hFFFFFFFC;
                m_mcause = m_lat_cause;
                m_mpie   = m_mie;
                m_mie    = 0;
            end else if (s.upd == 2) begin
                m_mie  = m_mpie;
                m_mpie = 1;
            end
            void'(sched.pop_front());
        end else if (e_trap) begin
            m_lat_pc    = pc;
            m_lat_cause = e_cause;
            sched.push_back('{stall: 1'b1, ovr: 1'b0, tgt_src: 0, upd: 1});
            sched.push_back('{stall: 1'b0, ovr: 1'b1, tgt_src: 1, upd: 0});
        end else if (e_mret) begin
            sched.push_back('{stall: 1'b0, ovr: 1'b1, tgt_src: 2, upd: 2});
        end else if (csr_wen) begin
            if (csr_addr == 12'h300) begin
                m_mie  = csr_wdata[3];
                m_mpie = csr_wdata[7];
            end else if (csr_addr == 12'h341) begin
                m_mepc = csr_wdata & 32'hFFFFFFFC;
            end else if (csr_addr == 12'h342) begin
                m_mcause = csr_wdata;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mtvec = 32'h201;
        clear_inputs();
        fill_table();

        // Reset state, with an ecall presented to confirm kill is held low
        valid = 1; ecall = 1;
        @(negedge clk);
        chk("reset_kill",     {31'b0, kill},  32'd0);
        chk("reset_stall",    {31'b0, stall}, 32'd0);
        chk("reset_override", {31'b0, ovr},   32'd0);
        chk("reset_busy",     {31'b0, busy},  32'd0);
        chk("reset_mstatus",  mstatus,        32'h0);
        chk("reset_mepc",     mepc,           32'h0);
        chk("reset_mcause",   mcause,         32'h0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            apply_vec(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d_kill", i),     {31'b0, kill},  {31'b0, tbl[i].ctl[3]});
            chk($sformatf("row%0d_stall", i),    {31'b0, stall}, {31'b0, tbl[i].ctl[2]});
            chk($sformatf("row%0d_override", i), {31'b0, ovr},   {31'b0, tbl[i].ctl[1]});
            chk($sformatf("row%0d_busy", i),     {31'b0, busy},  {31'b0, tbl[i].ctl[0]});
            if (tbl[i].ctl[1]) chk($sformatf("row%0d_target", i), target, tbl[i].tgt);
            chk($sformatf("row%0d_mstatus", i), mstatus, tbl[i].ms);
            chk($sformatf("row%0d_mepc", i),    mepc,    tbl[i].mepc);
            chk($sformatf("row%0d_mcause", i),  mcause,  tbl[i].mcause);
            @(posedge clk);
            #1;
        end

        // Masked interrupts held with MIE=0: nothing happens, registers keep their values
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            valid = 1; pc = 32'h600 + 32'(i * 4); irq_ext = 1; irq_tmr = 1;
            @(negedge clk);
            chk($sformatf("mask%0d_kill", i),     {31'b0, kill},  32'd0);
            chk($sformatf("mask%0d_stall", i),    {31'b0, stall}, 32'd0);
            chk($sformatf("mask%0d_override", i), {31'b0, ovr},   32'd0);
            chk($sformatf("mask%0d_mstatus", i),  mstatus, 32'h80);
            chk($sformatf("mask%0d_mepc", i),     mepc,    32'h80);
            chk($sformatf("mask%0d_mcause", i),   mcause,  32'h3);
            @(posedge clk);
            #1;
        end

        // Reset arriving mid-trap (during SAVE) abandons the redirect
        clear_inputs();
        valid = 1; pc = 32'h500; ecall = 1;
        @(negedge clk);
        chk("rsave_entry_kill", {31'b0, kill}, 32'd1);
        @(posedge clk);
        #1;
        chk("rsave_stall", {31'b0, stall}, 32'd1);
        chk("rsave_busy",  {31'b0, busy},  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rsave_async_stall",    {31'b0, stall}, 32'd0);
        chk("rsave_async_kill",     {31'b0, kill},  32'd0);
        chk("rsave_async_override", {31'b0, ovr},   32'd0);
        chk("rsave_async_busy",     {31'b0, busy},  32'd0);
        chk("rsave_async_mepc",     mepc,           32'h0);
        chk("rsave_async_mcause",   mcause,         32'h0);
        chk("rsave_async_mstatus",  mstatus,        32'h0);
        @(posedge clk);
        #1;
        chk("rsave_held_override", {31'b0, ovr},  32'd0);
        chk("rsave_held_kill",     {31'b0, kill}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rsave_post%0d_override", i), {31'b0, ovr},   32'd0);
            chk($sformatf("rsave_post%0d_stall", i),    {31'b0, stall}, 32'd0);
            chk($sformatf("rsave_post%0d_busy", i),     {31'b0, busy},  32'd0);
            chk($sformatf("rsave_post%0d_mepc", i),     mepc,           32'h0);
        end

        // Randomized run from the post-reset state
        m_mie = 0; m_mpie = 0; m_mepc = '0; m_mcause = '0;
        m_lat_pc = '0; m_lat_cause = '0;
        sched.delete();
        for (int n = 0; n < 1500; n++) random_cycle(n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
